// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth UART transmit and receive blocks:
// state encoding, oversampling ratio and the baud tick divider formula.
package bt_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StStart  = START,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP
  } bt_state_e;

  // Last value of the oversampling tick counter; one tick per 1/16 bit.
  function automatic int unsigned tick_max(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE) - 1;
  endfunction

endpackage

// File: rtl/bt_baud_tick.sv
// 16x oversampling tick generator with synchronous clear, shared by the
// Bluetooth UART transmitter and receiver.
module bt_baud_tick
  import bt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] TickMax = 16'(tick_max(CLK_FREQ, BAUD_RATE));

  logic [15:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TickMax);

  always_comb begin
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    if (clear) cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bt_rx.sv
// Bluetooth UART receiver: 8N1 frames, 16x oversampling, mid-bit sampling.
// Define BT_RX_PARITY_EN to receive 8E1 frames instead.
module bt_rx
  import bt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_error
);

  logic rx_s1, rx_s2, rx_prev;
  logic tick, tick_clear;

  bt_state_e   state_q, state_d;
  logic [3:0]  sample_cnt_q, sample_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        frame_ok;
`ifdef BT_RX_PARITY_EN
  logic        parity_err_q, parity_err_d;
`endif

  bt_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

`ifdef BT_RX_PARITY_EN
  assign frame_ok = rx_s2 & ~parity_err_q;
`else
  assign frame_ok = rx_s2;
`endif

  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = tick ? sample_cnt_q + 4'd1 : sample_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    tick_clear    = 1'b0;
`ifdef BT_RX_PARITY_EN
    parity_err_d  = parity_err_q;
`endif

    case (state_q)
      StIdle: begin
        // Edge-triggered so a line stuck low cannot restart the receiver.
        if (rx_prev && !rx_s2) begin
          state_d      = StStart;
          sample_cnt_d = 4'd0;
          tick_clear   = 1'b1;
        end
      end
      StStart: begin
        if (tick && sample_cnt_q == 4'd7) begin
          if (!rx_s2) begin
            state_d      = StData;
            sample_cnt_d = 4'd0;
            bit_cnt_d    = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick && sample_cnt_q == 4'd15) begin
          shift_d   = {rx_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef BT_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef BT_RX_PARITY_EN
      StParity: begin
        if (tick && sample_cnt_q == 4'd15) begin
          parity_err_d = rx_s2 ^ (^shift_q);
          state_d      = StStop;
        end
      end
`endif
      StStop: begin
        if (tick && sample_cnt_q == 4'd15) begin
          if (frame_ok) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      state_q       <= StIdle;
      sample_cnt_q  <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef BT_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_s1         <= rx;
      rx_s2         <= rx_s1;
      rx_prev       <= rx_s2;
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
`ifdef BT_RX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_bt_rx.sv
// Scoreboard bench for bt_rx: stimulus pushes the expected strobe of each frame,
// a monitor pops and compares whenever data_valid or frame_error fires.
module tb_bt_rx;

  localparam int unsigned CLK_FREQ  = 1600000;
  localparam int unsigned BAUD_RATE = 10000;
  localparam int          BIT_CLKS  = 160;
`ifdef BT_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam int EXP_LAT = 3 + 80 + 10 * BIT_CLKS;
`else
  localparam bit PAR_EN  = 1'b0;
  localparam int EXP_LAT = 3 + 80 + 9 * BIT_CLKS;
`endif

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_error;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;

  bt_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outcome comes straight from the frame rules: good iff stop is 1
  // and (with parity) the parity bit equals the XOR of the data bits.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit par);
    bit good;
    @(posedge clk);
    #1;
    good = stop && (!PAR_EN || (par == ^b));
    exp_q.push_back('{err: !good, data: (good ? b : last_good), t_edge: cyc});
    if (good) last_good = b;
    rx = 1'b0;
    hold(20);
    check(busy == 1'b1, "busy_in_frame", 32'(busy), 32'd1);
    hold(BIT_CLKS - 20);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(BIT_CLKS);
    end
    if (PAR_EN) begin
      rx = par;
      hold(BIT_CLKS);
    end
    rx = stop;
    hold(BIT_CLKS);
    if (!stop) begin
      rx = 1'b1;
      hold(BIT_CLKS);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!reset && (data_valid || frame_error)) begin
      check(!(data_valid && frame_error), "strobe_exclusive",
            32'({data_valid, frame_error}), 32'd0);
      check(!prev_strobe, "strobe_width", 32'(prev_strobe), 32'd0);
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_strobe", 32'({data_valid, frame_error}), 32'd0);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e.t_edge;
        check(frame_error == e.err, "strobe_kind", 32'(frame_error), 32'(e.err));
        check(data_out == e.data, "data_out", 32'(data_out), 32'(e.data));
        check(lat >= EXP_LAT - 8 && lat <= EXP_LAT + 8, "strobe_latency", 32'(lat),
              32'(EXP_LAT));
      end
    end
    prev_strobe <= !reset && (data_valid || frame_error);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bit         stop;
    bit         par;

    hold(5);
    reset = 1'b0;
    hold(3);
    check(data_out == 8'h00, "reset_data_out", 32'(data_out), 32'h0);
    check({data_valid, frame_error, busy} == 3'b000, "reset_flags",
          32'({data_valid, frame_error, busy}), 32'h0);

    // Single frame, then back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b1, ^8'h55);
    hold(30);
    check(busy == 1'b0, "busy_idle", 32'(busy), 32'd0);
    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    hold(50);

    // Short low pulse must be rejected as a false start.
    rx = 1'b0;
    hold(40);
    rx = 1'b1;
    hold(20);
    check(busy == 1'b1, "glitch_detected", 32'(busy), 32'd1);
    hold(200);
    check(busy == 1'b0, "glitch_rejected", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    hold(50);

    // Bad stop bit, then recovery.
    send_frame(8'h81, 1'b0, ^8'h81);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    hold(50);

    // Reset in the middle of bit 4 of 0xFF.
    rx = 1'b0;
    hold(BIT_CLKS);
    rx = 1'b1;
    hold(4 * BIT_CLKS + 80);
    check(busy == 1'b1, "busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    hold(2);
    @(negedge clk);
    check(data_out == 8'h00, "abort_data_out", 32'(data_out), 32'h0);
    check({data_valid, frame_error, busy} == 3'b000, "abort_flags",
          32'({data_valid, frame_error, busy}), 32'h0);
    last_good = 8'h00;
    hold(1);
    reset = 1'b0;
    hold(5 * BIT_CLKS);
    check(busy == 1'b0, "post_reset_idle", 32'(busy), 32'd0);
    send_frame(8'h12, 1'b1, ^8'h12);
    hold(50);

`ifdef BT_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    hold(50);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(50);
`endif

    // Randomised frames: occasional bad stop bit / parity, random idle gaps.
    for (int n = 0; n < 8; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      par  = ($urandom_range(0, 3) == 0) ? ~(^b) : ^b;
      send_frame(b, stop, par);
      hold($urandom_range(0, 100));
    end

    hold(20);
    check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check(busy == 1'b0, "final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
